seg_scan: RTL

Four-digit, time-multiplexed seven-segment display driver: the output-side companion to the push-button debounce front end. It takes a 16-bit hex value plus per-digit blank and decimal-point masks and scans them onto common-anode display pins, one digit at a time. New values are double-buffered and committed only at a frame boundary, so the display never shows a mix of old and new digits.

---
 rtl/seg_scan_if.sv | 25 ++
 rtl/seg_scan.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Bus bundle for the seg_scan display driver: the data/strobe inputs plus
// the scanned display pins and status flags.
interface seg_scan_if;
    logic [15:0] value_i;
    logic [3:0]  blank_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;
    logic        pending_o;

    // Producer of display values; observes the pins.
    modport master (
        output value_i, blank_i, dp_i, load_i,
        input  an_o, seg_o, dp_o, frame_o, pending_o
    );

    // The display driver itself.
    modport slave (
        input  value_i, blank_i, dp_i, load_i,
        output an_o, seg_o, dp_o, frame_o, pending_o
    );
endinterface

// File: rtl/seg_scan.sv
// Four-digit time-multiplexed seven-segment driver with a double-buffered
// value: loads land in a pending buffer and are committed to the display
// buffer only when the scan wraps back to digit 0.
//
// Handshake: load_i is a single-cycle strobe with no ready; every strobe is
// accepted and overwrites any not-yet-committed pending data.
module seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input logic      clk_i,
    input logic      rst_ni,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] div_cnt;
    logic [1:0]    digit_q;

    logic [15:0]   pend_val;
    logic [3:0]    pend_blank;
    logic [3:0]    pend_dp;
    logic          pend;

    logic [15:0]   disp_val;
    logic [3:0]    disp_blank;
    logic [3:0]    disp_dp;

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_q;

    logic          tick;
    logic          wrap;
    logic          commit;
    logic [1:0]    digit_nxt;
    logic [15:0]   sel_val;
    logic [3:0]    sel_blank;
    logic [3:0]    sel_dp;
    logic [3:0]    nib;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Tick/wrap detection and selection of the data the next digit decodes
    // from; on a committing wrap the freshly committed data is used directly.
    always_comb begin
        tick      = (div_cnt == CW'(REFRESH_DIV - 1));
        wrap      = tick && (digit_q == 2'd3);
        commit    = wrap && pend;
        digit_nxt = digit_q + 2'd1;
        sel_val   = commit ? pend_val   : disp_val;
        sel_blank = commit ? pend_blank : disp_blank;
        sel_dp    = commit ? pend_dp    : disp_dp;
        nib       = sel_val[{digit_nxt, 2'b00} +: 4];
    end

    // Scan counter, buffers and registered display outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt    <= '0;
            digit_q    <= 2'd3;
            pend_val   <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            disp_val   <= '0;
            disp_blank <= '0;
            disp_dp    <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                digit_q <= digit_nxt;
                frame_q <= wrap;
                if (sel_blank[digit_nxt]) begin
                    an_q  <= 4'b1111;
                    seg_q <= 7'h7F;
                    dp_q  <= 1'b1;
                end else begin
                    an_q  <= ~(4'b0001 << digit_nxt);
                    seg_q <= hex7(nib);
                    dp_q  <= ~sel_dp[digit_nxt];
                end
                if (commit) begin
                    disp_val   <= pend_val;
                    disp_blank <= pend_blank;
                    disp_dp    <= pend_dp;
                    pend       <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                frame_q <= 1'b0;
            end
            // A load on the commit edge refills the pending buffer after the
            // old contents have been committed, so pend stays set.
            if (bus.load_i) begin
                pend_val   <= bus.value_i;
                pend_blank <= bus.blank_i;
                pend_dp    <= bus.dp_i;
                pend       <= 1'b1;
            end
        end
    end

    assign bus.an_o      = an_q;
    assign bus.seg_o     = seg_q;
    assign bus.dp_o      = dp_q;
    assign bus.frame_o   = frame_q;
    assign bus.pending_o = pend;

endmodule
